// File: rtl/cam_stream_gen.sv
// cam_stream_gen
//
// Camera stream generator in the pixel-clock domain. It emulates an
// OV7670-style YUV422 (YUYV) sensor. Each frame has programmable
// vsync/back-porch/active/front-porch line counts and a solid background
// with one foreground rectangle. It stands in for the sensor in front of
// the UV bounding-box capture block.
//
// Ports
//   pclk         in   pixel clock; all outputs change on its rising edge
//   reset        in   asynchronous, active-high
//   enable       in   start frames and keep streaming while high
//   box_x0/x1    in   inclusive foreground column range (10 bit)
//   box_y0/y1    in   inclusive foreground row range (10 bit)
//   fg_y/u/v     in   foreground Y/U/V bytes
//   bg_y/u/v     in   background Y/U/V bytes
//   href         out  active byte qualifier
//   vsync        out  frame sync, active-high
//   cam_data     out  YUYV byte stream, 0 while href is low
//   frame_start  out  one-cycle pulse on the first vsync-high cycle
//   frame_done   out  one-cycle pulse on the last cycle of the frame
//
// state    | meaning
// ---------+---------------------------------------------------
// S_IDLE   | no frame in progress, waiting for enable
// S_VSYNC  | vsync-high line periods
// S_VBACK  | blank lines between vsync and the first active line
// S_ACTIVE | active lines, href bursts carrying pixel data
// S_VFRONT | blank lines after the last active line

module cam_stream_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] box_x0,
    input  logic [9:0] box_x1,
    input  logic [9:0] box_y0,
    input  logic [9:0] box_y1,
    input  logic [7:0] fg_y,
    input  logic [7:0] fg_u,
    input  logic [7:0] fg_v,
    input  logic [7:0] bg_y,
    input  logic [7:0] bg_u,
    input  logic [7:0] bg_v,
    output logic       href,
    output logic       vsync,
    output logic [7:0] cam_data,
    output logic       frame_start,
    output logic       frame_done
);

    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int HW       = $clog2(LINE_LEN);

    localparam logic [HW-1:0] LINE_LAST = HW'(LINE_LEN - 1);
    localparam logic [HW-1:0] ACT_BYTES = HW'(2 * H_ACTIVE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_VFRONT
    } state_t;

    // First and last states of a frame that actually hold lines; empty
    // states are skipped entirely.
    localparam state_t FIRST_ST = (VSYNC_LINES > 0) ? S_VSYNC :
                                  (V_BACK > 0)      ? S_VBACK :
                                  (V_ACTIVE > 0)    ? S_ACTIVE : S_VFRONT;
    localparam state_t LAST_ST  = (V_FRONT > 0)     ? S_VFRONT :
                                  (V_ACTIVE > 0)    ? S_ACTIVE :
                                  (V_BACK > 0)      ? S_VBACK  : S_VSYNC;

    state_t        state, state_nx;
    logic [HW-1:0] hcnt;
    logic [9:0]    lcnt;

    // Frame-latched configuration
    logic [9:0] x0_r, x1_r, y0_r, y1_r;
    logic [7:0] fgy_r, fgu_r, fgv_r, bgy_r, bgu_r, bgv_r;

    logic       line_end, last_line, frame_last, cfg_load;
    logic [9:0] cur_lines;
    logic [9:0] px;
    logic       in_active, fg_hit;
    logic [7:0] data_nx;

    function automatic logic [9:0] lines_of(input state_t s);
        case (s)
            S_VSYNC:  return 10'(VSYNC_LINES);
            S_VBACK:  return 10'(V_BACK);
            S_ACTIVE: return 10'(V_ACTIVE);
            S_VFRONT: return 10'(V_FRONT);
            default:  return 10'd0;
        endcase
    endfunction

    // Walk forward past zero-length states so they take no cycles.
    function automatic state_t skip_empty(input state_t s, input logic en);
        state_t r;
        r = s;
        for (int i = 0; i < 5; i++) begin
            case (r)
                S_VSYNC:  if (VSYNC_LINES == 0) r = S_VBACK;
                S_VBACK:  if (V_BACK == 0)      r = S_ACTIVE;
                S_ACTIVE: if (V_ACTIVE == 0)    r = S_VFRONT;
                S_VFRONT: if (V_FRONT == 0)     r = en ? S_VSYNC : S_IDLE;
                default:  ;
            endcase
        end
        return r;
    endfunction

    assign cur_lines  = lines_of(state);
    assign line_end   = (hcnt == LINE_LAST);
    assign last_line  = (lcnt == cur_lines - 10'd1);
    assign frame_last = (state == LAST_ST) && line_end && last_line;
    assign cfg_load   = enable && ((state == S_IDLE) || frame_last);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:
                if (enable) state_nx = skip_empty(S_VSYNC, enable);
            S_VSYNC:
                if (line_end && last_line) state_nx = skip_empty(S_VBACK, enable);
            S_VBACK:
                if (line_end && last_line) state_nx = skip_empty(S_ACTIVE, enable);
            S_ACTIVE:
                if (line_end && last_line) state_nx = skip_empty(S_VFRONT, enable);
            S_VFRONT:
                if (line_end && last_line)
                    state_nx = enable ? skip_empty(S_VSYNC, enable) : S_IDLE;
            default:
                state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            hcnt  <= '0;
            lcnt  <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE) begin
                hcnt <= '0;
                lcnt <= '0;
            end else begin
                hcnt <= line_end ? '0 : hcnt + 1'b1;
                if (line_end)
                    lcnt <= last_line ? 10'd0 : lcnt + 10'd1;
            end
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            x0_r  <= '0;
            x1_r  <= '0;
            y0_r  <= '0;
            y1_r  <= '0;
            fgy_r <= '0;
            fgu_r <= '0;
            fgv_r <= '0;
            bgy_r <= '0;
            bgu_r <= '0;
            bgv_r <= '0;
        end else if (cfg_load) begin
            x0_r  <= box_x0;
            x1_r  <= box_x1;
            y0_r  <= box_y0;
            y1_r  <= box_y1;
            fgy_r <= fg_y;
            fgu_r <= fg_u;
            fgv_r <= fg_v;
            bgy_r <= bg_y;
            bgu_r <= bg_u;
            bgv_r <= bg_v;
        end
    end

    // Each 4-byte group is one pixel pair; px is the left pixel's column.
    // Within S_ACTIVE, lcnt is the active row number.
    assign px        = {9'(hcnt >> 2), 1'b0};
    assign in_active = (state == S_ACTIVE) && (hcnt < ACT_BYTES);
    // An inverted range fails one of the two bounds, so an empty box needs
    // no separate check.
    assign fg_hit    = (px >= x0_r) && (px <= x1_r) &&
                       (lcnt >= y0_r) && (lcnt <= y1_r);

    always_comb begin
        data_nx = 8'd0;
        if (in_active) begin
            case (hcnt[1:0])
                2'd0, 2'd2: data_nx = fg_hit ? fgy_r : bgy_r;
                2'd1:       data_nx = fg_hit ? fgu_r : bgu_r;
                default:    data_nx = fg_hit ? fgv_r : bgv_r;
            endcase
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            href        <= 1'b0;
            vsync       <= 1'b0;
            cam_data    <= 8'd0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            href        <= in_active;
            vsync       <= (state == S_VSYNC);
            cam_data    <= data_nx;
            frame_start <= (state == FIRST_ST) && (lcnt == 10'd0) && (hcnt == '0);
            frame_done  <= frame_last;
        end
    end

endmodule
